// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game: display state codes, BCD limits and LFSR constants.
package reaction_pkg;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_WAIT   = 3'b001;
    localparam logic [2:0] ST_FAIL   = 3'b010;
    localparam logic [2:0] ST_GO     = 3'b011;
    localparam logic [2:0] ST_RESULT = 3'b111;
    localparam logic [2:0] ST_BEST   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_WAIT   = ST_WAIT,
        S_FAIL   = ST_FAIL,
        S_GO     = ST_GO,
        S_RESULT = ST_RESULT,
        S_BEST   = ST_BEST
    } state_e;

    localparam logic [15:0] BCD_MAX   = 16'h9999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd4_counter.sv
// Four-digit BCD up-counter with synchronous clear and saturation at 9999.
module bcd4_counter
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        carry;

    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && cnt_q != BCD_MAX) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (cnt_q[4*i +: 4] == 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Round sequencer for the reaction-time game: random GO delay, BCD reaction timing, best-time tracking.
//  state  | meaning
//  IDLE   | power-up / after leaving best view
//  WAIT   | random delay running, early react is a false start
//  FAIL   | false start or GO timeout
//  GO     | timing the reaction in ms
//  RESULT | valid reaction shown
//  BEST   | best time view
module reaction_game_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        react_btn,
    input  logic        best_btn,
    output logic [2:0]  state,
    output logic [15:0] act_time,
    output logic [15:0] max_result
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e      state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] best_q, best_d;
    logic [15:0] act_q;
    logic        tick;
    logic        tmr_last;
    logic        enter_wait;
    logic        act_clr;
    logic        act_inc;

    bcd4_counter u_act (
        .clk (clk),
        .rst (rst),
        .clr (act_clr),
        .inc (act_inc),
        .cnt (act_q)
    );

    always_comb begin
        tick       = (presc_q == PW'(TICK_DIV - 1));
        tmr_last   = (tmr_q <= 16'd1);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        lfsr_d     = lfsr_next(lfsr_q);
        state_d    = state_q;
        tmr_d      = tmr_q;
        best_d     = best_q;
        enter_wait = 1'b0;
        act_clr    = 1'b0;
        act_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_btn)     enter_wait = 1'b1;
                else if (best_btn) state_d    = S_BEST;
            end
            S_WAIT: begin
                if (react_btn) begin
                    state_d = S_FAIL;
                end else if (tick) begin
                    if (tmr_last) begin
                        state_d = S_GO;
                        presc_d = '0;
                        act_clr = 1'b1;
                        tmr_d   = 16'(TIMEOUT_MS);
                    end else begin
                        tmr_d = tmr_q - 16'd1;
                    end
                end
            end
            S_GO: begin
                // A react on a tick edge freezes the time at its pre-tick value.
                if (react_btn) begin
                    state_d = S_RESULT;
                    if (act_q < best_q) best_d = act_q;
                end else if (tick) begin
                    act_inc = 1'b1;
                    if (tmr_last) state_d = S_FAIL;
                    else          tmr_d   = tmr_q - 16'd1;
                end
            end
            S_RESULT, S_FAIL: begin
                if (start_btn)     enter_wait = 1'b1;
                else if (best_btn) state_d    = S_BEST;
            end
            S_BEST: begin
                if (start_btn)     enter_wait = 1'b1;
                else if (best_btn) state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_wait) begin
            state_d = S_WAIT;
            presc_d = '0;
            tmr_d   = 16'(MIN_DELAY_MS) + 16'(lfsr_q[RAND_BITS-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            tmr_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            best_q  <= BCD_MAX;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tmr_q   <= tmr_d;
            lfsr_q  <= lfsr_d;
            best_q  <= best_d;
        end
    end

    assign state      = state_q;
    assign act_time   = act_q;
    assign max_result = best_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Randomised self-checking bench for reaction_game_ctrl against a ms-level round model.
module tb_reaction_game_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b0, react_btn = 1'b0, best_btn = 1'b0;
    logic [2:0]  state;
    logic [15:0] act_time, max_result;

    logic        l_start = 1'b0;
    logic [2:0]  l_state;
    logic [15:0] l_act, l_max;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;
    logic [15:0] cap_lfsr;
    int          exp_delay;
    int          exp_act  = 0;
    int          exp_best = 9999;

    reaction_game_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(3), .RAND_BITS(2), .TIMEOUT_MS(300)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .react_btn(react_btn), .best_btn(best_btn),
        .state(state), .act_time(act_time), .max_result(max_result)
    );

    reaction_game_ctrl #(.TICK_DIV(4), .MIN_DELAY_MS(3), .RAND_BITS(2), .TIMEOUT_MS(9999)) dut_l (
        .clk(clk), .rst(rst), .start_btn(l_start), .react_btn(1'b0), .best_btn(1'b0),
        .state(l_state), .act_time(l_act), .max_result(l_max)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seeded on reset, steps every clock.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic r, input logic b);
        @(negedge clk);
        start_btn = s; react_btn = r; best_btn = b;
        cap_lfsr  = m_lfsr;
        @(negedge clk);
        start_btn = 1'b0; react_btn = 1'b0; best_btn = 1'b0;
    endtask

    task automatic start_round(input logic with_best);
        pulse(1'b1, 1'b0, with_best);
        exp_delay = 3 + int'(cap_lfsr[1:0]);
        chk("start_to_wait", 16'(state), 16'h0001);
    endtask

    task automatic wait_go();
        repeat (4 * exp_delay - 1) @(negedge clk);
        chk("wait_hold", 16'(state), 16'h0001);
        @(negedge clk);
        chk("go_entry", 16'(state), 16'h0003);
        exp_act = 0;
        chk("go_act_clr", act_time, 16'h0000);
    endtask

    // React sampled j+2 cycles after GO entry; ticks strictly before that edge count.
    task automatic react_go(input int j);
        int m;
        repeat (j) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        m = j + 2;
        exp_act = (m - 1) / 4;
        if (exp_act < exp_best) exp_best = exp_act;
        chk("result_state", 16'(state), 16'h0007);
        chk("result_act", act_time, to_bcd(exp_act));
        chk("result_best", max_result, to_bcd(exp_best));
    endtask

    task automatic false_start(input int j);
        repeat (j) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        chk("false_state", 16'(state), 16'h0002);
        chk("false_act", act_time, to_bcd(exp_act));
        chk("false_best", max_result, to_bcd(exp_best));
    endtask

    initial begin
        logic [15:0] prev;
        bit seen_a, seen_b, done;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 16'(state), 16'h0000);
        chk("rst_act", act_time, 16'h0000);
        chk("rst_best", max_result, 16'h9999);
        repeat (5) @(negedge clk);
        chk("idle_stable", 16'(state), 16'h0000);

        start_round(1'b0);
        false_start(2);

        start_round(1'b0);
        wait_go();
        react_go(491);

        start_round(1'b0);
        wait_go();
        react_go(999);
        pulse(1'b0, 1'b0, 1'b1);
        chk("best_view", 16'(state), 16'h0006);
        chk("best_view_act", act_time, 16'h0250);
        chk("best_view_max", max_result, 16'h0123);
        pulse(1'b0, 1'b0, 1'b1);
        chk("best_to_idle", 16'(state), 16'h0000);

        start_round(1'b0);
        wait_go();
        pulse(1'b1, 1'b0, 1'b1);
        chk("go_ignores_start", 16'(state), 16'h0003);
        repeat (1197) @(negedge clk);
        chk("pre_timeout_state", 16'(state), 16'h0003);
        chk("pre_timeout_act", act_time, 16'h0299);
        @(negedge clk);
        chk("timeout_state", 16'(state), 16'h0002);
        chk("timeout_act", act_time, 16'h0300);
        chk("timeout_best", max_result, 16'h0123);
        exp_act = 300;
        pulse(1'b0, 1'b1, 1'b0);
        chk("fail_ignores_react", 16'(state), 16'h0002);

        start_round(1'b0);
        false_start(4 * exp_delay - 2);

        start_round(1'b0);
        wait_go();
        react_go(38);

        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("back_to_idle", 16'(state), 16'h0000);
        start_round(1'b1);
        false_start($urandom_range(0, 4 * exp_delay - 2));

        for (int r = 0; r < 10; r++) begin
            start_round(1'b0);
            if ($urandom_range(0, 3) == 0) begin
                false_start($urandom_range(0, 4 * exp_delay - 2));
            end else begin
                wait_go();
                react_go($urandom_range(0, 1100));
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse(1'b0, 1'b0, 1'b1);
                chk("rand_best_view", 16'(state), 16'h0006);
                chk("rand_best_max", max_result, to_bcd(exp_best));
            end
        end

        start_round(1'b0);
        wait_go();
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 16'(state), 16'h0000);
        chk("async_rst_act", act_time, 16'h0000);
        chk("async_rst_best", max_result, 16'h9999);
        exp_act  = 0;
        exp_best = 9999;
        @(negedge clk);
        rst = 1'b0;
        start_round(1'b0);
        wait_go();
        react_go($urandom_range(0, 1100));

        @(negedge clk);
        l_start = 1'b1;
        @(negedge clk);
        l_start = 1'b0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (l_state == 3'b011) done = 1;
        end
        chk("long_go_reached", 16'(done), 16'h0001);
        seen_a = 0; seen_b = 0; done = 0;
        for (int i = 0; i < 41000 && !done; i++) begin
            prev = l_act;
            @(negedge clk);
            if (prev == 16'h0099 && l_act != prev) begin
                chk("carry_0099", l_act, 16'h0100);
                seen_a = 1;
            end
            if (prev == 16'h0999 && l_act != prev) begin
                chk("carry_0999", l_act, 16'h1000);
                seen_b = 1;
            end
            if (l_state != 3'b011) done = 1;
        end
        chk("long_seen_0100", 16'(seen_a), 16'h0001);
        chk("long_seen_1000", 16'(seen_b), 16'h0001);
        chk("long_timeout_state", 16'(l_state), 16'h0002);
        chk("long_final_act", l_act, 16'h9999);
        chk("long_best", l_max, 16'h9999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
